// File: rtl/mux_rr_arbiter_if.sv
// Two-source byte stream bundle plus the registered output stream.
// The master drives the sources and the sink ready; the slave is the arbiter.
interface mux_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b;
  logic             b_valid;
  logic             b_ready;
  logic             sel;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             y_ready;

  modport master (
    output a, a_valid,
    output b, b_valid,
    output y_ready,
    input  a_ready, b_ready,
    input  sel, y, y_valid
  );

  modport slave (
    input  a, a_valid,
    input  b, b_valid,
    input  y_ready,
    output a_ready, b_ready,
    output sel, y, y_valid
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Burst-limited round-robin arbiter for two byte streams feeding a 2:1 mux,
// with a one-entry registered valid/ready output.
module mux_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4
) (
  input logic              clk,
  input logic              rst,
  mux_rr_arbiter_if.slave  bus
);

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  localparam logic [7:0] BL = 8'(BURST_LEN);

  owner_t           owner;
  logic [7:0]       cnt;
  logic [WIDTH-1:0] y_q;
  logic             y_valid_q;

  logic space;
  logic both;
  logic any;
  logic pick_b;
  logic take_a;
  logic take_b;
  logic xfer;
  logic same;

  always_comb begin
    space  = !y_valid_q || bus.y_ready;
    both   = bus.a_valid && bus.b_valid;
    any    = bus.a_valid || bus.b_valid;
    pick_b = 1'b0;
    // Under contention the owner keeps the bus until its burst is spent.
    if (both) begin
      pick_b = (owner == OWN_B) ^ (cnt == BL);
    end else if (bus.b_valid) begin
      pick_b = 1'b1;
    end
    take_a = space && any && !pick_b && !rst;
    take_b = space && pick_b && !rst;
    xfer   = take_a || take_b;
    same   = pick_b == (owner == OWN_B);
  end

  assign bus.a_ready = take_a;
  assign bus.b_ready = take_b;
  assign bus.sel     = any ? pick_b : (owner == OWN_B);
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= OWN_A;
      cnt       <= 8'd0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else if (xfer) begin
      y_q       <= take_b ? bus.b : bus.a;
      y_valid_q <= 1'b1;
      if (same) begin
        if (cnt < BL) begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        owner <= pick_b ? OWN_B : OWN_A;
        cnt   <= 8'd1;
      end
    end else if (bus.y_ready) begin
      y_valid_q <= 1'b0;
    end
  end

  never_both: assert property (
    @(posedge clk) !(take_a && take_b)
  );

  hold_stall: assert property (
    @(posedge clk) disable iff (rst)
    (y_valid_q && !bus.y_ready)
      |=> (y_valid_q && $stable(y_q))
  );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench: stimulus queues expected beats, negedge monitors pop them.
// A BURST_LEN=4 instance covers most cases; a BURST_LEN=1 one covers alternation.
module tb_mux_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.WIDTH(8)) bus4 ();
  mux_rr_arbiter_if #(.WIDTH(8)) bus1 ();

  mux_rr_arbiter #(.WIDTH(8), .BURST_LEN(4)) u4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  mux_rr_arbiter #(.WIDTH(8), .BURST_LEN(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] q4[$];
  logic [7:0] q1[$];
  logic [7:0] inc4a = 8'd1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus4.y_valid && bus4.y_ready) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL y4: got %0h expected none", bus4.y);
      end else begin
        chk("y4", bus4.y, q4.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus1.y_valid && bus1.y_ready) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL y1: got %0h expected none", bus1.y);
      end else begin
        chk("y1", bus1.y, q1.pop_front());
      end
    end
  end

  // Capture handshakes before the edge, then advance the source streams.
  task automatic adv();
    logic fa4, fb4, fa1, fb1;
    fa4 = bus4.a_valid && bus4.a_ready;
    fb4 = bus4.b_valid && bus4.b_ready;
    fa1 = bus1.a_valid && bus1.a_ready;
    fb1 = bus1.b_valid && bus1.b_ready;
    @(posedge clk);
    #1;
    if (fa4) bus4.a = bus4.a + inc4a;
    if (fb4) bus4.b = bus4.b + 8'd1;
    if (fa1) bus1.a = bus1.a + 8'd1;
    if (fb1) bus1.b = bus1.b + 8'd1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [8:0] selp3;
    logic [4:0] selp6;
    selp3 = 9'b011110000;
    selp6 = 5'b10000;
    bus4.a = 8'h00; bus4.a_valid = 1'b0;
    bus4.b = 8'h00; bus4.b_valid = 1'b0;
    bus4.y_ready = 1'b1;
    bus1.a = 8'h00; bus1.a_valid = 1'b0;
    bus1.b = 8'h00; bus1.b_valid = 1'b0;
    bus1.y_ready = 1'b1;

    // T1 reset with both sources valid
    rst = 1'b1;
    bus4.a_valid = 1'b1;
    bus4.b_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("t1 y_valid", bus4.y_valid, 0);
      chk("t1 y", bus4.y, 0);
      chk("t1 a_ready", bus4.a_ready, 0);
      chk("t1 b_ready", bus4.b_ready, 0);
      chk("t1 sel", bus4.sel, 0);
      adv();
    end

    // T2 lone A stream
    rst = 1'b0;
    bus4.b_valid = 1'b0;
    bus4.a = 8'h11;
    inc4a = 8'h11;
    q4.push_back(8'h11);
    q4.push_back(8'h22);
    q4.push_back(8'h33);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2 a_ready", bus4.a_ready, 1);
      chk("t2 b_ready", bus4.b_ready, 0);
      chk("t2 sel", bus4.sel, 0);
      adv();
    end
    bus4.a_valid = 1'b0;
    @(negedge clk);
    chk("t2 last y", bus4.y, 8'h33);
    chk("t2 idle sel", bus4.sel, 0);
    adv();
    @(negedge clk);
    chk("t2 drained", bus4.y_valid, 0);
    adv();

    // T3 contention, bursts of 4
    rst = 1'b1;
    @(negedge clk);
    adv();
    rst = 1'b0;
    inc4a = 8'd1;
    bus4.a = 8'hA0;
    bus4.b = 8'hB0;
    bus4.a_valid = 1'b1;
    bus4.b_valid = 1'b1;
    for (int i = 0; i < 4; i++) q4.push_back(8'hA0 + 8'(i));
    for (int i = 0; i < 4; i++) q4.push_back(8'hB0 + 8'(i));
    q4.push_back(8'hA4);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("t3 sel", bus4.sel, selp3[i]);
      chk("t3 a_ready", bus4.a_ready, !selp3[i]);
      adv();
    end
    bus4.a_valid = 1'b0;
    bus4.b_valid = 1'b0;

    // T4 backpressure
    bus4.a = 8'h5A;
    bus4.a_valid = 1'b1;
    q4.push_back(8'h5A);
    q4.push_back(8'h5B);
    @(negedge clk);
    chk("t4 a_ready", bus4.a_ready, 1);
    adv();
    bus4.y_ready = 1'b0;
    bus4.b_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t4 hold y", bus4.y, 8'h5A);
      chk("t4 hold valid", bus4.y_valid, 1);
      chk("t4 stall a", bus4.a_ready, 0);
      chk("t4 stall b", bus4.b_ready, 0);
      adv();
    end
    bus4.y_ready = 1'b1;
    @(negedge clk);
    chk("t4 resume a", bus4.a_ready, 1);
    adv();
    bus4.a_valid = 1'b0;
    bus4.b_valid = 1'b0;
    @(negedge clk);
    chk("t4 next y", bus4.y, 8'h5B);
    chk("t4 next valid", bus4.y_valid, 1);
    adv();

    // T6 reset mid B burst; C1 is in flight and dropped
    rst = 1'b1;
    @(negedge clk);
    adv();
    rst = 1'b0;
    bus4.b = 8'hC0;
    bus4.b_valid = 1'b1;
    q4.push_back(8'hC0);
    repeat (2) begin
      @(negedge clk);
      chk("t6 b_ready", bus4.b_ready, 1);
      chk("t6 sel b", bus4.sel, 1);
      adv();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("t6 rst b_ready", bus4.b_ready, 0);
    chk("t6 rst a_ready", bus4.a_ready, 0);
    adv();
    rst = 1'b0;
    bus4.a = 8'hD0;
    bus4.a_valid = 1'b1;
    for (int i = 0; i < 4; i++) q4.push_back(8'hD0 + 8'(i));
    q4.push_back(8'hC2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) chk("t6 dropped", bus4.y_valid, 0);
      chk("t6 sel", bus4.sel, selp6[i]);
      adv();
    end
    bus4.a_valid = 1'b0;
    bus4.b_valid = 1'b0;

    // T5 strict alternation with bursts of 1
    bus1.a = 8'hA0;
    bus1.b = 8'hB0;
    bus1.a_valid = 1'b1;
    bus1.b_valid = 1'b1;
    q1.push_back(8'hA0);
    q1.push_back(8'hB0);
    q1.push_back(8'hA1);
    q1.push_back(8'hB1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5 sel", bus1.sel, 32'(i % 2));
      adv();
    end
    bus1.a_valid = 1'b0;
    bus1.b_valid = 1'b0;

    for (int k = 0; k < 20 && (q4.size() != 0 || q1.size() != 0); k++)
      @(negedge clk);
    chk("q4 drained", q4.size(), 0);
    chk("q1 drained", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
